// File: rtl/npc_regf_pkg.sv
// Shared sizing constants for the npc register file.
// CPU_WIDTH and REG_NUM from defines.v correspond to XLEN and NREG.
package npc_regf_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 16;
    localparam int unsigned A0_IDX = 10;

endpackage

// File: rtl/regf_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight writes and raises RAW/WAW hazards.
module regf_scoreboard #(
    parameter  int unsigned NREG = 16,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_iss_valid,
    input  logic            i_iss_wen,
    input  logic [AW-1:0]   i_iss_rd,
    input  logic [AW-1:0]   i_iss_rs1,
    input  logic [AW-1:0]   i_iss_rs2,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic            i_flush,
    output logic            o_iss_ready,
    output logic [NREG-1:0] o_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            raw1;
    logic            raw2;
    logic            waw;
    logic            fire;

    // A same-cycle write-back to the hazard register resolves it through the bypass.
    always_comb begin
        raw1 = (i_iss_rs1 != '0) && busy_q[i_iss_rs1] && !(i_wb_en && (i_wb_addr == i_iss_rs1));
        raw2 = (i_iss_rs2 != '0) && busy_q[i_iss_rs2] && !(i_wb_en && (i_wb_addr == i_iss_rs2));
        waw  = i_iss_wen && (i_iss_rd != '0) && busy_q[i_iss_rd]
               && !(i_wb_en && (i_wb_addr == i_iss_rd));
        o_iss_ready = !i_flush && !raw1 && !raw2 && !waw;
        fire        = i_iss_valid && o_iss_ready;
    end

    // Clear on write-back, then set on issue so a new producer wins; flush clears all.
    always_comb begin
        busy_d = busy_q;
        if (i_wb_en) begin
            busy_d[i_wb_addr] = 1'b0;
        end
        if (fire && i_iss_wen) begin
            busy_d[i_iss_rd] = 1'b1;
        end
        if (i_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/stl_reg_p.sv
// Generic loadable register with synchronous active-low reset to RESET_VAL.
module stl_reg_p #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_dout <= RESET_VAL;
        end else if (i_wen) begin
            o_dout <= i_din;
        end
    end

endmodule

// File: rtl/regf_sb.sv
// Register file with write-back bypass, x0 hard-wired to zero and an issue scoreboard.
module regf_sb #(
    parameter  int unsigned XLEN = npc_regf_pkg::XLEN,
    parameter  int unsigned NREG = npc_regf_pkg::NREG,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_iss_valid,
    input  logic                 i_iss_wen,
    input  logic [AW-1:0]        i_iss_rd,
    input  logic [AW-1:0]        i_iss_rs1,
    input  logic [AW-1:0]        i_iss_rs2,
    output logic                 o_iss_ready,
    output logic [XLEN-1:0]      o_rs1_data,
    output logic [XLEN-1:0]      o_rs2_data,
    input  logic                 i_wb_en,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [XLEN-1:0]      i_wb_data,
    input  logic                 i_flush,
    output logic [NREG-1:0]      o_busy,
    output logic                 o_a0zero
`ifdef SIMULATION
    ,
    output logic [NREG*XLEN-1:0] o_flat_rf
`endif
);

    import npc_regf_pkg::*;

    logic [NREG-1:0][XLEN-1:0] rf;

    assign rf[0] = '0;

    // Storage for x1..x(NREG-1); reset priority inside stl_reg_p discards a write in the reset cycle.
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic wen;
        assign wen = i_wb_en && (i_wb_addr == AW'(r));
        stl_reg_p #(
            .WIDTH     (XLEN),
            .RESET_VAL ('0)
        ) u_reg (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_wen  (wen),
            .i_din  (i_wb_data),
            .o_dout (rf[r])
        );
    end

    // Read ports: x0 is zero, else bypass the live write-back, else stored value.
    always_comb begin
        o_rs1_data = '0;
        o_rs2_data = '0;
        if (i_iss_rs1 != '0) begin
            o_rs1_data = (i_wb_en && (i_wb_addr == i_iss_rs1)) ? i_wb_data : rf[i_iss_rs1];
        end
        if (i_iss_rs2 != '0) begin
            o_rs2_data = (i_wb_en && (i_wb_addr == i_iss_rs2)) ? i_wb_data : rf[i_iss_rs2];
        end
    end

    // a0 flag follows committed state only, never the bypass.
    if (NREG > A0_IDX) begin : g_a0
        assign o_a0zero = ~|rf[AW'(A0_IDX)];
    end else begin : g_no_a0
        assign o_a0zero = 1'b1;
    end

`ifdef SIMULATION
    assign o_flat_rf = rf;
`endif

    regf_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_iss_valid (i_iss_valid),
        .i_iss_wen   (i_iss_wen),
        .i_iss_rd    (i_iss_rd),
        .i_iss_rs1   (i_iss_rs1),
        .i_iss_rs2   (i_iss_rs2),
        .i_wb_en     (i_wb_en),
        .i_wb_addr   (i_wb_addr),
        .i_flush     (i_flush),
        .o_iss_ready (o_iss_ready),
        .o_busy      (o_busy)
    );

endmodule

// File: tb/tb_regf_sb.sv
// Scoreboard bench for regf_sb: directed scenarios then random traffic vs a register/pending-set model.
module tb_regf_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 iss_valid;
    logic                 iss_wen;
    logic [AW-1:0]        iss_rd;
    logic [AW-1:0]        iss_rs1;
    logic [AW-1:0]        iss_rs2;
    logic                 iss_ready;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;
    logic [NREG-1:0]      busy;
    logic                 a0zero;
    logic [NREG*XLEN-1:0] flat;

    always #5 clk = ~clk;

    regf_sb #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_iss_valid (iss_valid),
        .i_iss_wen   (iss_wen),
        .i_iss_rd    (iss_rd),
        .i_iss_rs1   (iss_rs1),
        .i_iss_rs2   (iss_rs2),
        .o_iss_ready (iss_ready),
        .o_rs1_data  (rs1_data),
        .o_rs2_data  (rs2_data),
        .i_wb_en     (wb_en),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (wb_data),
        .i_flush     (flush),
        .o_busy      (busy),
        .o_a0zero    (a0zero)
`ifdef SIMULATION
        ,
        .o_flat_rf   (flat)
`endif
    );

    typedef struct {
        logic                 ready;
        logic [XLEN-1:0]      d1;
        logic [XLEN-1:0]      d2;
        logic [NREG-1:0]      busy;
        logic                 a0z;
        logic [NREG*XLEN-1:0] flat;
    } exp_t;

    exp_t            expq[$];
    logic [XLEN-1:0] m_reg[NREG];
    bit              m_pend[NREG];
    int              n_chk = 0;
    int              n_fail = 0;
    bit              run = 1'b0;

    task automatic chk(input string name, input logic [NREG*XLEN-1:0] act, input logic [NREG*XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (run) begin
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL no_expectation: got empty queue expected one entry (t=%0t)", $time);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("iss_ready", {511'b0, iss_ready}, {511'b0, e.ready});
                chk("rs1_data", {480'b0, rs1_data}, {480'b0, e.d1});
                chk("rs2_data", {480'b0, rs2_data}, {480'b0, e.d2});
                chk("busy", {496'b0, busy}, {496'b0, e.busy});
                chk("a0zero", {511'b0, a0zero}, {511'b0, e.a0z});
`ifdef SIMULATION
                chk("flat_rf", flat, e.flat);
`endif
            end
        end
    end

    function automatic bit hz(input int s, input bit we, input int wa);
        return (s != 0) && m_pend[s] && !(we && wa == s);
    endfunction

    // One clock of stimulus: predict outputs from the model, push, then advance the model at the edge.
    task automatic cyc(input bit r, input bit v, input bit w, input int rd, input int s1, input int s2,
                       input bit we, input int wa, input logic [XLEN-1:0] wd, input bit fl);
        exp_t e;
        bit   rdy;
        rst = r; iss_valid = v; iss_wen = w;
        iss_rd = AW'(rd); iss_rs1 = AW'(s1); iss_rs2 = AW'(s2);
        wb_en = we; wb_addr = AW'(wa); wb_data = wd; flush = fl;
        rdy = !fl && !hz(s1, we, wa) && !hz(s2, we, wa) && !(w && hz(rd, we, wa));
        e.ready = rdy;
        e.d1 = (s1 == 0) ? '0 : ((we && wa == s1) ? wd : m_reg[s1]);
        e.d2 = (s2 == 0) ? '0 : ((we && wa == s2) ? wd : m_reg[s2]);
        for (int i = 0; i < NREG; i++) begin
            e.busy[i] = m_pend[i];
            e.flat[i*XLEN +: XLEN] = m_reg[i];
        end
        e.a0z = (m_reg[10] == 0);
        expq.push_back(e);
        run = 1'b1;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) m_reg[wa] = wd;
            if (fl) begin
                for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            end else begin
                if (we) m_pend[wa] = 1'b0;
                if (v && rdy && w && rd != 0) m_pend[rd] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_read(input int s1, input int s2);
        cyc(1, 0, 0, 0, s1, s2, 0, 0, '0, 0);
    endtask

    initial begin
        rst = 1'b0; iss_valid = 1'b0; iss_wen = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 1'b0;
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < NREG; i++) idle_read(i, NREG - 1 - i);

        // Bypass on x5, then stored value; x0 write ignored.
        cyc(1, 0, 0, 0, 5, 0, 1, 5, 32'hDEADBEEF, 0);
        idle_read(5, 5);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 0);
        idle_read(0, 0);

        // RAW on x3 resolved by same-cycle write-back.
        cyc(1, 1, 1, 3, 0, 0, 0, 0, '0, 0);
        cyc(1, 1, 0, 0, 3, 0, 0, 0, '0, 0);
        cyc(1, 1, 0, 0, 3, 0, 1, 3, 32'h77, 0);

        // Same-cycle clear and set on x7, then WAW stall until next write-back.
        cyc(1, 1, 1, 7, 0, 0, 1, 7, 32'h11, 0);
        cyc(1, 1, 1, 7, 0, 0, 0, 0, '0, 0);
        cyc(1, 1, 1, 7, 0, 0, 0, 0, '0, 0);
        cyc(1, 1, 1, 7, 7, 0, 1, 7, 32'h22, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 7, 32'h33, 0);

        // Flush with busy x2/x9 and a write-back to x9.
        cyc(1, 1, 1, 2, 0, 0, 0, 0, '0, 0);
        cyc(1, 1, 1, 9, 0, 0, 0, 0, '0, 0);
        cyc(1, 1, 1, 1, 2, 9, 1, 9, 32'h5, 1);
        idle_read(9, 2);

        // Busy x4, x10 = 1, then reset with a discarded write of x10.
        cyc(1, 1, 1, 4, 0, 0, 1, 10, 32'h1, 0);
        idle_read(10, 4);
        cyc(0, 1, 1, 6, 10, 0, 1, 10, 32'h0, 0);
        idle_read(10, 4);
        idle_read(5, 9);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            int wa;
            wa = int'($urandom_range(0, NREG - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = int'($urandom_range(1, NREG - 1));
                    if (m_pend[c]) wa = c;
                end
            end
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, NREG - 1)),
                int'($urandom_range(0, NREG - 1)),
                int'($urandom_range(0, NREG - 1)),
                ($urandom_range(0, 2) != 0),
                wa,
                ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                ($urandom_range(0, 19) == 0));
        end

        run = 1'b0;
        @(negedge clk);
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regf_sb.md
# regf_sb

Parametrised register file for the npc core with integrated write-back bypass and a per-register busy scoreboard. It sits between IDU and EXU/WBU. It supplies forwarded source operands and stalls issue on RAW/WAW hazards against writes still in flight, so the pipeline can run more than one instruction at a time. x0 stays hard-wired to zero. The a0-zero status flag is retained for the sim harness.

## Interface
- `XLEN`, 32, data width of each register.
- `NREG`, 16, number of architectural registers; power of two, at least 2 (16 = RV32E).
- `AW`, $clog2(NREG), register address width; derived, never overridden.
- `i_clk`  in  1  core clock, all state on rising edge.
- `i_rst`  in  1  reset; one clock, synchronous, active-low (0 = reset).
- `i_iss_valid`  in  1  IDU presents an instruction for issue.
- `i_iss_wen`  in  1  the instruction writes a destination register.
- `i_iss_rd`  in  AW  destination register.
- `i_iss_rs1`, `i_iss_rs2`  in  AW  source registers.
- `o_iss_ready`  out  1  issue may fire this cycle (no hazard, no flush).
- `o_rs1_data`, `o_rs2_data`  out  XLEN  forwarded source operands.
- `i_wb_en`  in  1  write-back valid.
- `i_wb_addr`  in  AW  write-back register.
- `i_wb_data`  in  XLEN  write-back data.
- `i_flush`  in  1  pipeline flush; clears all busy bits.
- `o_busy`  out  NREG  scoreboard vector; bit 0 always 0.
- `o_a0zero`  out  1  1 when x10 (a0) reads as zero.
- `o_flat_rf`  out  NREG*XLEN  only under `SIMULATION`; register r occupies bits [(r+1)*XLEN-1 -: XLEN].

## Operation
- Issue fires when `i_iss_valid && o_iss_ready`.
- Storage:
  - Registers 1..NREG-1 are written on a rising edge when `i_wb_en` is high and `i_wb_addr` is non-zero.
  - A write-back to x0 is ignored and clears nothing.
- Read and bypass:
  - `o_rsN_data` returns 0 if rsN = 0.
  - Otherwise it returns `i_wb_data` if `i_wb_en` is high and `i_wb_addr` equals rsN.
  - Otherwise it returns the stored value.
  - Reads are purely combinational.
- Scoreboard: busy[r] is set on an issue fire with `i_iss_wen` high and rd = r ≠ 0. It is cleared by a write-back to r.
- Same-cycle write-back clear and issue set on the same r: set wins, because the new producer owns r.
- Hazard: `o_iss_ready` = !i_flush && !raw1 && !raw2 && !waw.
  - rawN = rsN ≠ 0 && busy[rsN] && !(i_wb_en && i_wb_addr == rsN). A write-back in the same cycle resolves the hazard via the bypass.
  - waw = i_iss_wen && i_iss_rd ≠ 0 && busy[i_iss_rd] && !(i_wb_en && i_wb_addr == i_iss_rd).
- `o_iss_ready` does not depend on `i_iss_valid`.
- Flush:
  - All busy bits clear on the next edge.
  - Issue is blocked in the flush cycle.
  - A write-back in the flush cycle still updates data.
  - Later write-backs from squashed instructions still write data, which is harmless because the architectural state is re-fetched.
- A write-back to a register that is not busy writes data normally.
- `o_a0zero` = ~|stored x10. It is not bypassed and reflects committed state only.

## Timing
- Reset (`i_rst` = 0 at an edge):
  - All registers go to 0 and all busy bits to 0.
  - Any write-back or issue in that cycle is discarded.
- Output values in the cycle after reset: `o_iss_ready` = 1 (when `i_flush` = 0), `o_busy` = 0, `o_a0zero` = 1, read data = 0.
- Reset asserted mid-operation drops all outstanding busy state unconditionally.
- Write latency:
  - A written value is visible to readers in the same cycle via the bypass.
  - It appears in storage, `o_flat_rf` and `o_a0zero` after one edge.
- Scoreboard latency: a set or clear becomes visible in `o_busy` and `o_iss_ready` one edge after the event.
- Combinational paths: from i_iss_*, i_wb_*, i_flush to `o_iss_ready` and read data. There is no path from `i_iss_valid` to `o_iss_ready`.

## Structure
- Package `npc_regf_pkg`: `XLEN`, `NREG`, and the `A0_IDX` = 10 constant. `defines.v` `CPU_WIDTH` and `REG_NUM` map onto these.
- Storage per register uses the existing `stl_reg_p` (WIDTH = XLEN, RESET_VAL = 0).
- One new sub-module, `regf_scoreboard`:
  - Contains the NREG busy flops, the set/clear/flush priority logic and the hazard terms.
  - The top level keeps storage, bypass muxes and flags.

## Test plan
- Reset, then read x0..x15 -> all return 0, `o_busy` = 0, `o_a0zero` = 1, `o_iss_ready` = 1.
- Write-back x5 = 0xDEADBEEF while rs1 = 5 in the same cycle -> `o_rs1_data` = 0xDEADBEEF that cycle and stored value 0xDEADBEEF next cycle. Write-back x0 = 0x1234 -> x0 still reads 0.
- Issue rd = 3, then rs1 = 3 with no write-back -> `o_iss_ready` = 0. Write-back x3 = 0x77 in that cycle -> `o_iss_ready` = 1 and `o_rs1_data` = 0x77.
- Write-back x7 and issue rd = 7 in the same cycle -> busy[7] = 1 afterwards. Issue rd = 7 again next cycle -> stalled (WAW) until the next write-back to x7.
- Busy x2, x9 then `i_flush` = 1 with valid issue -> `o_iss_ready` = 0 that cycle, `o_busy` = 0 next cycle. A write-back to x9 = 0x5 in the flush cycle is stored.
- Busy x4 and x10 = 1, then `i_rst` = 0 for one cycle with write-back x10 = 0 -> afterwards all registers 0, `o_busy` = 0, `o_a0zero` = 1, and the discarded write leaves no trace.
